digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle successor to the combinational two-bit adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, least-significant digit first, reusing one DIGIT-bit adder slice.
- Valid/ready handshakes on input and output, so it sits between a register-file read stage and a writeback stage in the datapath lab designs.
- Produces sum, carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 1.
- DIGIT, 2, bits processed per clock; must divide WIDTH exactly. N = WIDTH/DIGIT is the number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result
- cout  output  1  carry-out (no-borrow when sub=1)
- ovf  output  1  two's-complement overflow

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). rst is sampled only at the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, digit counter=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b_eff (b, or ~b if sub), and carry (cin, or 1 if sub); clear the sum register; go to RUN with cnt=0.
  - RUN: in_ready=0. Each edge adds digit cnt of a and b_eff plus the carry register. The DIGIT result bits are written into sum[cnt*DIGIT +: DIGIT] and the carry register is updated. At cnt==N-1, go to DONE; otherwise cnt+1.
  - DONE: out_valid=1. sum, cout and ovf are stable and held until out_ready=1. On out_valid&&out_ready, go to IDLE and drop out_valid.
- Outputs at DONE:
  - cout = final carry.
  - ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
- Latency: out_valid rises exactly N edges after the accepting edge. Throughput is one operation per N+2 cycles with out_ready held high.
- Input acceptance:
  - No acceptance in RUN or DONE.
  - in_valid is ignored there.
  - a, b, cin and sub may change freely after acceptance without affecting the result.
- No overlap: in_ready does not rise in the same cycle as the output handshake. It rises the cycle after.
- Arithmetic: the result is modulo 2^WIDTH; the carry beyond WIDTH goes only to cout.
- DIGIT==WIDTH is legal (N=1, single RUN cycle).
- sum/cout/ovf retain their last values in IDLE; consumers use them only when out_valid=1.
- Reset in any state (including mid-RUN or DONE with out_ready=0):
  - Next cycle is IDLE with all reset values; the partial result is discarded.
  - rst has priority over a simultaneous handshake.

Test Plan:
- WIDTH=8, DIGIT=2: a=0x5A, b=0x3C, cin=0, sub=0 -> out_valid 4 edges after accept; sum=0x96, cout=0, ovf=1.
- WIDTH=8, DIGIT=2: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x10, b=0x20, sub=1, cin=1 -> sum=0xF0, cout=0, ovf=0 (cin ignored).
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, and toggle in_valid with new a/b -> sum/cout/ovf/out_valid unchanged, in_ready=0, new operands not taken; out_ready=1 -> IDLE next cycle with in_ready=1.
- Reset mid-operation: assert rst on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0. A fresh 0x01+0x01 then yields sum=0x02.
- Exhaustive, WIDTH=2, DIGIT=1 (N=2): all 16 a/b pairs with cin=0 and cin=1, back-to-back with out_ready=1 -> {cout,sum}==a+b+cin every time; ovf matches the signed check; out_valid spaced every 4 cycles.
- WIDTH=8, DIGIT=8 (N=1): a=0x7F, b=0x01 -> sum=0x80, ovf=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: one DIGIT-bit slice reused over WIDTH/DIGIT cycles,
// least-significant digit first, with valid/ready handshakes on both sides.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [31:0]      lsb;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dig_res;

  assign lsb     = 32'(cnt_q) * DIGIT;
  assign a_dig   = a_q[lsb +: DIGIT];
  assign b_dig   = b_q[lsb +: DIGIT];
  assign dig_res = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so cin is overridden by the forced carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[lsb +: DIGIT] = dig_res[DIGIT-1:0];
        carry_d             = dig_res[DIGIT];
        if (cnt_q == LastCnt) begin
          // The last digit carries the result MSB, so overflow is decided here.
          cout_d  = dig_res[DIGIT];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (dig_res[DIGIT-1] != a_q[WIDTH-1]);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: three parameterisations (8/2, 2/1, 8/8) sharing
// one clock and reset, checked with immediate assertions.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       u0_in_valid, u0_in_ready, u0_cin, u0_sub, u0_out_valid, u0_out_ready;
  logic [7:0] u0_a, u0_b, u0_sum;
  logic       u0_cout, u0_ovf;

  logic       u1_in_valid, u1_in_ready, u1_cin, u1_sub, u1_out_valid, u1_out_ready;
  logic [1:0] u1_a, u1_b, u1_sum;
  logic       u1_cout, u1_ovf;

  logic       u2_in_valid, u2_in_ready, u2_cin, u2_sub, u2_out_valid, u2_out_ready;
  logic [7:0] u2_a, u2_b, u2_sum;
  logic       u2_cout, u2_ovf;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(u0_in_valid), .in_ready(u0_in_ready), .a(u0_a), .b(u0_b),
    .cin(u0_cin), .sub(u0_sub), .out_valid(u0_out_valid), .out_ready(u0_out_ready),
    .sum(u0_sum), .cout(u0_cout), .ovf(u0_ovf)
  );

  digit_serial_adder #(.WIDTH(2), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready), .a(u1_a), .b(u1_b),
    .cin(u1_cin), .sub(u1_sub), .out_valid(u1_out_valid), .out_ready(u1_out_ready),
    .sum(u1_sum), .cout(u1_cout), .ovf(u1_ovf)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(u2_in_valid), .in_ready(u2_in_ready), .a(u2_a), .b(u2_b),
    .cin(u2_cin), .sub(u2_sub), .out_valid(u2_out_valid), .out_ready(u2_out_ready),
    .sum(u2_sum), .cout(u2_cout), .ovf(u2_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with u0 idle; returns edges from accept to out_valid (0 = never).
  task automatic op0(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s,
                     output int lat);
    u0_a = av; u0_b = bv; u0_cin = c; u0_sub = s; u0_in_valid = 1'b1;
    @(posedge clk); #1;
    u0_in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (u0_out_valid) lat = k;
    end
  endtask

  task automatic finish0();
    u0_out_ready = 1'b1;
    @(posedge clk); #1;
    u0_out_ready = 1'b0;
    chk("u0_release_out_valid", 32'(u0_out_valid), 32'd0);
    chk("u0_release_in_ready", 32'(u0_in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int prev;
    int e, sa, sb, ss;
    logic eovf;

    rst = 1'b1;
    {u0_in_valid, u0_cin, u0_sub, u0_out_ready, u0_a, u0_b} = '0;
    {u1_in_valid, u1_cin, u1_sub, u1_out_ready, u1_a, u1_b} = '0;
    {u2_in_valid, u2_cin, u2_sub, u2_out_ready, u2_a, u2_b} = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(u0_in_ready), 32'd1);
    chk("reset_out_valid", 32'(u0_out_valid), 32'd0);
    chk("reset_sum", 32'(u0_sum), 32'd0);
    chk("reset_cout", 32'(u0_cout), 32'd0);
    chk("reset_ovf", 32'(u0_ovf), 32'd0);

    // 0x5A + 0x3C: positive + positive wraps negative
    op0(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
    chk("add1_latency", 32'(lat), 32'd4);
    chk("add1_sum", 32'(u0_sum), 32'h96);
    chk("add1_cout", 32'(u0_cout), 32'd0);
    chk("add1_ovf", 32'(u0_ovf), 32'd1);
    chk("add1_in_ready_done", 32'(u0_in_ready), 32'd0);
    finish0();

    op0(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    chk("add2_sum", 32'(u0_sum), 32'h00);
    chk("add2_cout", 32'(u0_cout), 32'd1);
    chk("add2_ovf", 32'(u0_ovf), 32'd0);
    finish0();

    // Subtract with cin=1, which must be ignored
    op0(8'h10, 8'h20, 1'b1, 1'b1, lat);
    chk("sub_sum", 32'(u0_sum), 32'hF0);
    chk("sub_cout", 32'(u0_cout), 32'd0);
    chk("sub_ovf", 32'(u0_ovf), 32'd0);
    finish0();

    // Backpressure: result held, new operands refused
    op0(8'h12, 8'h34, 1'b0, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      u0_in_valid = ~u0_in_valid;
      u0_a = 8'hFF; u0_b = 8'hFF; u0_cin = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(u0_out_valid), 32'd1);
      chk("bp_in_ready", 32'(u0_in_ready), 32'd0);
      chk("bp_sum", 32'(u0_sum), 32'h46);
      chk("bp_cout", 32'(u0_cout), 32'd0);
      chk("bp_ovf", 32'(u0_ovf), 32'd0);
    end
    u0_in_valid = 1'b0;
    finish0();
    chk("bp_sum_retained_idle", 32'(u0_sum), 32'h46);
    op0(8'h01, 8'h02, 1'b0, 1'b0, lat);
    chk("bp_next_sum", 32'(u0_sum), 32'h03);
    finish0();

    // Reset during the second RUN cycle
    u0_a = 8'h55; u0_b = 8'h11; u0_cin = 1'b0; u0_sub = 1'b0; u0_in_valid = 1'b1;
    @(posedge clk); #1;
    u0_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(u0_in_ready), 32'd1);
    chk("midrst_out_valid", 32'(u0_out_valid), 32'd0);
    chk("midrst_sum", 32'(u0_sum), 32'd0);
    chk("midrst_cout", 32'(u0_cout), 32'd0);
    op0(8'h01, 8'h01, 1'b0, 1'b0, lat);
    chk("midrst_next_latency", 32'(lat), 32'd4);
    chk("midrst_next_sum", 32'(u0_sum), 32'h02);
    finish0();

    // Exhaustive 2-bit, back-to-back with out_ready held
    u1_out_ready = 1'b1;
    u1_in_valid  = 1'b1;
    prev = -1;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          u1_a = 2'(ai); u1_b = 2'(bi); u1_cin = 1'(ci);
          chk("ex_in_ready", 32'(u1_in_ready), 32'd1);
          @(posedge clk); #1;
          lat = 0;
          for (int k = 1; k <= 10 && lat == 0; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (u1_out_valid) lat = k - 1;
            if (k == 10 && lat == 0) lat = 99;
          end
          e    = ai + bi + ci;
          sa   = (ai >= 2) ? ai - 4 : ai;
          sb   = (bi >= 2) ? bi - 4 : bi;
          ss   = sa + sb + ci;
          eovf = (ss > 1) || (ss < -2);
          chk("ex_latency", 32'(lat), 32'd2);
          chk("ex_cout_sum", 32'({u1_cout, u1_sum}), 32'(e));
          chk("ex_ovf", 32'(u1_ovf), 32'(eovf));
          if (prev >= 0) chk("ex_spacing", 32'(cyc - prev), 32'd4);
          prev = cyc;
          @(posedge clk); #1;
        end
      end
    end
    u1_in_valid = 1'b0;

    // DIGIT == WIDTH: single RUN cycle
    u2_a = 8'h7F; u2_b = 8'h01; u2_in_valid = 1'b1;
    @(posedge clk); #1;
    u2_in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (u2_out_valid) lat = k;
    end
    chk("n1_latency", 32'(lat), 32'd1);
    chk("n1_sum", 32'(u2_sum), 32'h80);
    chk("n1_cout", 32'(u2_cout), 32'd0);
    chk("n1_ovf", 32'(u2_ovf), 32'd1);
    u2_out_ready = 1'b1;
    @(posedge clk); #1;
    u2_out_ready = 1'b0;
    chk("n1_release_in_ready", 32'(u2_in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
